m_port_ultra_quickhull_sequencer: RTL and testbench
===================================================

M_PORT_ULTRA_QUICKHULL_SEQUENCER -- requirements
Module: m_port_ultra_quickhull_sequencer

Interface
REQ-001 SHALL have parameter MAX_PTS, default 256, the maximum points per set.
REQ-002 SHALL have parameter MIN_PTS, default 3, the minimum set size launched to the core.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum WAIT cycles before abort.
REQ-004 SHALL have ports `CLK100MHZ`  in  1  clock; `CPU_RESETN`  in  1  reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have ports `s_valid`  in  1, `s_ready`  out  1, `s_point`  in  16 {Y[15:8],X[7:0]}, `s_last`  in  1; these form the input point stream.
REQ-006 SHALL have ports `core_points`  out  4096, `core_ss`  out  9, `core_resetn`  out  1; these drive the hull core.
REQ-007 SHALL have ports `core_qend`  in  1, `core_convex_points`  in  4096, `core_convex_size`  in  8; these carry hull core results.
REQ-008 SHALL have ports `m_valid`  out  1, `m_ready`  in  1, `m_point`  out  16, `m_last`  out  1; these form the hull output stream.
REQ-009 SHALL have ports `busy`  out  1, `done`  out  1 pulse, `err_short`  out  1 pulse, `err_timeout`  out  1 pulse.

Function
REQ-010 SHALL implement states LOAD, LAUNCH, WAIT, UNLOAD.
- LOAD→LAUNCH on accepting the final beat with count≥MIN_PTS.
- LOAD→LOAD on short set.
- LAUNCH→WAIT after 2 cycles.
- WAIT→UNLOAD on `core_qend`=1 with size>0.
- WAIT→LOAD on timeout or size=0.
- UNLOAD→LOAD after the `m_last` handshake.
REQ-011 SHALL assert `s_ready`=1 only in LOAD; a beat is accepted when `s_valid`&&`s_ready`.
REQ-012 SHALL write accepted beat k (k=0..MAX_PTS-1) to `core_points`[16k+15:16k] and increment a 9-bit count.
REQ-013 SHALL clear `core_points` to zero on the first beat of each set, so unused slots read 0.
REQ-014 SHALL treat a beat as final when `s_last`=1 or it is beat MAX_PTS (count reaches 256); beats after that wait in the next set.
REQ-015 SHALL, for a final count<MIN_PTS, pulse `err_short` for 1 cycle, discard the set, and stay in LOAD without touching `core_ss`.
REQ-016 SHALL load `core_ss` with the final count on the LOAD→LAUNCH transition; `core_points` and `core_ss` SHALL stay stable until the next set's first beat.
REQ-017 SHALL drive `core_resetn`=0 in LOAD and LAUNCH (≥2 cycles low) and 1 in WAIT and UNLOAD.
REQ-018 SHALL sample `core_qend` only in WAIT; the first sample SHALL be at least 1 cycle after `core_resetn` rises.
REQ-019 SHALL snapshot `core_convex_points` and `core_convex_size` into holding registers on the WAIT→UNLOAD edge.
REQ-020 SHALL keep `core_resetn`=1 during UNLOAD so core results stay frozen.
REQ-021 SHALL count WAIT cycles in a 20-bit counter; on reaching TIMEOUT_CYCLES it SHALL pulse `err_timeout` and go to LOAD, dropping `core_resetn`.
REQ-022 SHALL, when `core_qend`=1 with `core_convex_size`=0, pulse `err_timeout` and go to LOAD.
REQ-023 SHALL, in UNLOAD, present held point j at `m_point`, with j from 0 to size-1 from bits [16j+15:16j].
- `m_valid`=1 throughout.
- `m_last`=1 iff j=size-1.
- j advances only on `m_valid`&&`m_ready`.
REQ-024 SHALL hold `m_point`/`m_last` stable while `m_valid`&&!`m_ready`; `m_valid` SHALL NOT drop before the handshake.
REQ-025 SHALL pulse `done` for 1 cycle in the cycle after the `m_last` handshake, simultaneous with the return to LOAD.
REQ-026 SHALL drive `busy`=1 in LAUNCH, WAIT, UNLOAD and also in LOAD once count>0.
REQ-027 SHALL have latency: final beat accepted at cycle T → `core_resetn` rises at T+3; `core_qend` seen at W → `m_valid`=1 at W+1.
REQ-028 SHALL give `s_valid` held high during non-LOAD states no effect (no beat lost, no beat accepted).

Reset
REQ-029 SHALL, on `CPU_RESETN`=0 asynchronously and at any time, enter LOAD with count=0, j=0, timer=0.
REQ-030 SHALL reset outputs to: `core_resetn`=0, `s_ready`=0, `m_valid`=0, `m_last`=0, `m_point`=0, `core_points`=0, `core_ss`=0, `busy`=0, `done`=0, `err_short`=0, `err_timeout`=0.
REQ-031 SHALL drive `s_ready`=1 from the first clock edge after reset release.
REQ-032 SHALL discard a partial set or in-flight hull on reset mid-operation; no `m_valid` or `done` SHALL follow.

Verification
REQ-033 SHALL cover: 4 points (10,10),(50,10),(50,50),(10,50), `s_last` on 4th, core model qend=1 after 100 cycles with size=4 → `core_ss`=4, `core_resetn` low 2 cycles, 4 `m_point` beats, `m_last` on 4th, `done` pulse.
REQ-034 SHALL cover: 2 points with `s_last` → `err_short` pulse, `core_resetn` stays 0, no `m_valid`, next set accepted normally.
REQ-035 SHALL cover: 256 beats with `s_last`=0 → load closes at beat 256, `core_ss`=256, 257th beat accepted only as the first beat of the next set.
REQ-036 SHALL cover: `m_ready` toggling 1-0-0-1 during a size=5 unload → each `m_point` stable while stalled, exactly 5 handshakes, in order.
REQ-037 SHALL cover: core model never raises qend, TIMEOUT_CYCLES=50 → `err_timeout` pulse at WAIT cycle 50, `core_resetn`=0 the next cycle, return to LOAD.
REQ-038 SHALL cover: `CPU_RESETN` low mid-UNLOAD (j=2) → `m_valid`=0 immediately, no `done`, clean new set after release.

Source files
------------

// File: rtl/m_port_ultra_quickhull_sequencer.sv
// Sequencer between a point stream and a quickhull core: gathers a point set, launches the
// core with a timed reset release, waits for its result and streams the hull back out.
module m_port_ultra_quickhull_sequencer #(
   parameter int unsigned MAX_PTS        = 256,
   parameter int unsigned MIN_PTS        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                     CLK100MHZ,
   input  logic                     CPU_RESETN,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [15:0]              s_point,
   input  logic                     s_last,
   output logic [16*MAX_PTS-1:0]    core_points,
   output logic [8:0]               core_ss,
   output logic                     core_resetn,
   input  logic                     core_qend,
   input  logic [16*MAX_PTS-1:0]    core_convex_points,
   input  logic [7:0]               core_convex_size,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [15:0]              m_point,
   output logic                     m_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err_short,
   output logic                     err_timeout
);

   typedef enum logic [1:0] {StLoad, StLaunch, StWait, StUnload} seqStateT;

   localparam logic [8:0]  LastIdx     = 9'(MAX_PTS - 1);
   localparam logic [8:0]  MinPts      = 9'(MIN_PTS);
   localparam logic [19:0] TimeoutLast = 20'(TIMEOUT_CYCLES - 1);
   localparam logic        TimeoutNow  = 1'(TIMEOUT_CYCLES <= 1);

   seqStateT               state;
   logic [8:0]             count;
   logic                   launchCnt;
   logic [19:0]            timer;
   logic [16*MAX_PTS-1:0]  holdPoints;
   logic [7:0]             holdSize;
   logic [7:0]             j;

   logic                   accept;
   logic                   finalBeat;
   logic [8:0]             countNext;
   logic [7:0]             jNext;
   logic [19:0]            timerNext;

   assign accept    = s_valid & s_ready;
   assign finalBeat = s_last | (count == LastIdx);
   assign countNext = count + 9'd1;
   assign jNext     = j + 8'd1;
   assign timerNext = timer + 20'd1;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state       <= StLoad;
         count       <= '0;
         launchCnt   <= 1'b0;
         timer       <= '0;
         holdPoints  <= '0;
         holdSize    <= '0;
         j           <= '0;
         s_ready     <= 1'b0;
         core_points <= '0;
         core_ss     <= '0;
         core_resetn <= 1'b0;
         m_valid     <= 1'b0;
         m_point     <= '0;
         m_last      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_short   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done        <= 1'b0;
         err_short   <= 1'b0;
         err_timeout <= 1'b0;
         unique case (state)
            StLoad: begin
               s_ready     <= 1'b1;
               core_resetn <= 1'b0;
               if (accept) begin
                  // First beat of a set wipes the previous set so unused slots read zero.
                  if (count == 9'd0) core_points <= '0;
                  core_points[16*count[7:0] +: 16] <= s_point;
                  if (finalBeat) begin
                     count <= '0;
                     if (countNext < MinPts) begin
                        err_short <= 1'b1;
                        busy      <= 1'b0;
                     end else begin
                        core_ss   <= countNext;
                        state     <= StLaunch;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        launchCnt <= 1'b0;
                     end
                  end else begin
                     count <= countNext;
                     busy  <= 1'b1;
                  end
               end
            end
            StLaunch: begin
               if (launchCnt) begin
                  state       <= StWait;
                  core_resetn <= 1'b1;
                  timer       <= '0;
                  err_timeout <= TimeoutNow;
               end else begin
                  launchCnt <= 1'b1;
               end
            end
            StWait: begin
               // The timeout pulse is raised during the last allowed WAIT cycle; leave on the next.
               if (timer == TimeoutLast) begin
                  state       <= StLoad;
                  core_resetn <= 1'b0;
                  s_ready     <= 1'b1;
                  busy        <= 1'b0;
                  timer       <= '0;
               end else if (core_qend) begin
                  if (core_convex_size != 8'd0) begin
                     state      <= StUnload;
                     holdPoints <= core_convex_points;
                     holdSize   <= core_convex_size;
                     j          <= '0;
                     m_valid    <= 1'b1;
                     m_point    <= core_convex_points[15:0];
                     m_last     <= (core_convex_size == 8'd1);
                  end else begin
                     err_timeout <= 1'b1;
                     state       <= StLoad;
                     core_resetn <= 1'b0;
                     s_ready     <= 1'b1;
                     busy        <= 1'b0;
                     timer       <= '0;
                  end
               end else begin
                  timer       <= timerNext;
                  err_timeout <= (timerNext == TimeoutLast);
               end
            end
            StUnload: begin
               if (m_ready) begin
                  if (m_last) begin
                     state       <= StLoad;
                     m_valid     <= 1'b0;
                     m_last      <= 1'b0;
                     done        <= 1'b1;
                     core_resetn <= 1'b0;
                     s_ready     <= 1'b1;
                     busy        <= 1'b0;
                  end else begin
                     j       <= jNext;
                     m_point <= holdPoints[16*jNext +: 16];
                     m_last  <= (jNext == holdSize - 8'd1);
                  end
               end
            end
            default: state <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_m_port_ultra_quickhull_sequencer.sv
// Directed bench for the quickhull sequencer: load, short set, full set, timeout, stalled
// unload and reset during unload, each against hand-computed values.
module tb_m_port_ultra_quickhull_sequencer;

   localparam int unsigned MaxPts = 256;

   logic                  CLK100MHZ = 1'b0;
   logic                  CPU_RESETN;
   logic                  s_valid;
   logic                  s_ready;
   logic [15:0]           s_point;
   logic                  s_last;
   logic [16*MaxPts-1:0]  core_points;
   logic [8:0]            core_ss;
   logic                  core_resetn;
   logic                  core_qend;
   logic [16*MaxPts-1:0]  core_convex_points;
   logic [7:0]            core_convex_size;
   logic                  m_valid;
   logic                  m_ready;
   logic [15:0]           m_point;
   logic                  m_last;
   logic                  busy;
   logic                  done;
   logic                  err_short;
   logic                  err_timeout;

   int                    checks = 0;
   int                    errors = 0;
   int                    hs;
   logic [15:0]           expPts [8];
   logic                  pat [4];

   m_port_ultra_quickhull_sequencer #(
      .MAX_PTS        (MaxPts),
      .MIN_PTS        (3),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .CLK100MHZ          (CLK100MHZ),
      .CPU_RESETN         (CPU_RESETN),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_point            (s_point),
      .s_last             (s_last),
      .core_points        (core_points),
      .core_ss            (core_ss),
      .core_resetn        (core_resetn),
      .core_qend          (core_qend),
      .core_convex_points (core_convex_points),
      .core_convex_size   (core_convex_size),
      .m_valid            (m_valid),
      .m_ready            (m_ready),
      .m_point            (m_point),
      .m_last             (m_last),
      .busy               (busy),
      .done               (done),
      .err_short          (err_short),
      .err_timeout        (err_timeout)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick;
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sendBeat(input logic [15:0] p, input logic last);
      s_valid = 1'b1;
      s_point = p;
      s_last  = last;
      tick;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Called in the cycle after the final beat; ends in the first WAIT cycle.
   task automatic launchSeq(input logic [8:0] ss);
      chk("launch_ss", 32'(core_ss), 32'(ss));
      chk("launch_sready", 32'(s_ready), 0);
      chk("launch_rstn_1", 32'(core_resetn), 0);
      tick;
      chk("launch_rstn_2", 32'(core_resetn), 0);
      tick;
      chk("wait_rstn_high", 32'(core_resetn), 1);
   endtask

   task automatic coreFinish(input int n);
      core_convex_points = '0;
      for (int i = 0; i < n; i++) core_convex_points[16*i +: 16] = expPts[i];
      core_convex_size = 8'(n);
      core_qend = 1'b1;
      tick;
      chk("unload_valid", 32'(m_valid), 1);
   endtask

   task automatic drain(input int n);
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk("drain_point", 32'(m_point), 32'(expPts[i]));
         chk("drain_last", 32'(m_last), 32'(i == n - 1));
         tick;
      end
      chk("done_pulse", 32'(done), 1);
      chk("done_mvalid", 32'(m_valid), 0);
      chk("done_rstn", 32'(core_resetn), 0);
      chk("done_sready", 32'(s_ready), 1);
      chk("done_busy", 32'(busy), 0);
      m_ready   = 1'b0;
      core_qend = 1'b0;
      tick;
      chk("done_clear", 32'(done), 0);
   endtask

   initial begin
      CPU_RESETN         = 1'b0;
      s_valid            = 1'b0;
      s_point            = '0;
      s_last             = 1'b0;
      core_qend          = 1'b0;
      core_convex_points = '0;
      core_convex_size   = '0;
      m_ready            = 1'b0;
      pat                = '{1'b1, 1'b0, 1'b0, 1'b1};
      expPts = '{16'h0A0A, 16'h0A32, 16'h3232, 16'h320A, 16'h0, 16'h0, 16'h0, 16'h0};

      // Reset values
      tick;
      tick;
      chk("rst_sready", 32'(s_ready), 0);
      chk("rst_core_rstn", 32'(core_resetn), 0);
      chk("rst_mvalid", 32'(m_valid), 0);
      chk("rst_mlast", 32'(m_last), 0);
      chk("rst_mpoint", 32'(m_point), 0);
      chk("rst_core_ss", 32'(core_ss), 0);
      chk("rst_core_points", 32'(|core_points), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", 32'({done, err_short, err_timeout}), 0);
      CPU_RESETN = 1'b1;
      tick;
      chk("rel_sready", 32'(s_ready), 1);

      // Square, hull of size 4
      for (int i = 0; i < 4; i++) sendBeat(expPts[i], (i == 3));
      chk("sq_slot0", 32'(core_points[15:0]), 32'h0A0A);
      chk("sq_slot1", 32'(core_points[31:16]), 32'h0A32);
      chk("sq_slot3", 32'(core_points[63:48]), 32'h320A);
      chk("sq_slot4", 32'(core_points[79:64]), 0);
      chk("sq_busy", 32'(busy), 1);
      launchSeq(9'd4);
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("sq_wait_mvalid", 32'(m_valid), 0);
      end
      coreFinish(4);
      drain(4);

      // Short set of two points
      sendBeat(16'h0102, 1'b0);
      chk("short_busy", 32'(busy), 1);
      sendBeat(16'h0304, 1'b1);
      chk("short_err", 32'(err_short), 1);
      chk("short_sready", 32'(s_ready), 1);
      chk("short_ss_kept", 32'(core_ss), 4);
      chk("short_rstn", 32'(core_resetn), 0);
      chk("short_busy_off", 32'(busy), 0);
      chk("short_slot0", 32'(core_points[15:0]), 32'h0102);
      chk("short_slot2", 32'(core_points[47:32]), 0);
      tick;
      chk("short_err_clear", 32'(err_short), 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("short_no_mvalid", 32'(m_valid), 0);
      end
      chk("short_rstn_low", 32'(core_resetn), 0);

      // 256 beats without s_last, then a timeout with s_valid held high
      s_valid = 1'b1;
      s_last  = 1'b0;
      for (int k = 0; k < 256; k++) begin
         s_point = {8'(k) ^ 8'hA5, 8'(k)};
         tick;
      end
      s_point = 16'hBEEF;
      chk("full_slot0", 32'(core_points[15:0]), 32'hA500);
      chk("full_slot128", 32'(core_points[16*128 +: 16]), 32'h2580);
      chk("full_slot255", 32'(core_points[16*255 +: 16]), 32'h5AFF);
      launchSeq(9'd256);
      for (int n = 1; n < 50; n++) begin
         chk("tmo_quiet", 32'(err_timeout), 0);
         tick;
      end
      chk("tmo_pulse", 32'(err_timeout), 1);
      chk("tmo_rstn_high", 32'(core_resetn), 1);
      chk("tmo_no_accept", 32'(s_ready), 0);
      tick;
      chk("tmo_pulse_end", 32'(err_timeout), 0);
      chk("tmo_rstn_low", 32'(core_resetn), 0);
      chk("tmo_sready", 32'(s_ready), 1);
      chk("tmo_busy", 32'(busy), 0);
      tick;
      s_valid = 1'b0;
      chk("b257_busy", 32'(busy), 1);
      chk("b257_slot0", 32'(core_points[15:0]), 32'hBEEF);
      chk("b257_slot1", 32'(core_points[31:16]), 0);
      chk("b257_ss_kept", 32'(core_ss), 256);

      // Size-5 unload with m_ready pattern 1-0-0-1
      expPts = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0};
      for (int i = 1; i < 5; i++) sendBeat(expPts[i], (i == 4));
      launchSeq(9'd5);
      tick;
      tick;
      coreFinish(5);
      hs = 0;
      for (int c = 0; c < 40 && hs < 5; c++) begin
         m_ready = pat[c % 4];
         chk("stall_valid", 32'(m_valid), 1);
         chk("stall_point", 32'(m_point), 32'(expPts[hs]));
         chk("stall_last", 32'(m_last), 32'(hs == 4));
         if (m_valid && m_ready) hs++;
         tick;
      end
      chk("stall_handshakes", 32'(hs), 5);
      chk("stall_done", 32'(done), 1);
      m_ready   = 1'b0;
      core_qend = 1'b0;
      tick;

      // Reset during unload at j=2
      expPts = '{16'h0A0A, 16'h0A32, 16'h3232, 16'h320A, 16'h0, 16'h0, 16'h0, 16'h0};
      for (int i = 0; i < 4; i++) sendBeat(expPts[i], (i == 3));
      launchSeq(9'd4);
      coreFinish(4);
      m_ready = 1'b1;
      tick;
      tick;
      m_ready = 1'b0;
      chk("mid_point_j2", 32'(m_point), 32'h3232);
      tick;
      chk("mid_point_held", 32'(m_point), 32'h3232);
      chk("mid_valid_held", 32'(m_valid), 1);
      #2;
      CPU_RESETN = 1'b0;
      #1;
      chk("mid_rst_mvalid", 32'(m_valid), 0);
      chk("mid_rst_rstn", 32'(core_resetn), 0);
      chk("mid_rst_ss", 32'(core_ss), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      core_qend        = 1'b0;
      core_convex_size = '0;
      tick;
      tick;
      chk("mid_rst_done", 32'(done), 0);
      CPU_RESETN = 1'b1;
      tick;
      chk("after_rst_sready", 32'(s_ready), 1);
      chk("after_rst_mvalid", 32'(m_valid), 0);
      chk("after_rst_done", 32'(done), 0);
      expPts = '{16'h0201, 16'h0403, 16'h0605, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      for (int i = 0; i < 3; i++) sendBeat(expPts[i], (i == 2));
      launchSeq(9'd3);
      tick;
      coreFinish(3);
      drain(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
